// File: rtl/serial_add_pkg.sv
// Shared types and constants for the digit-serial adder controller.
package serial_add_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder4bit.sv
// 4-bit ripple adder used as the single per-digit arithmetic stage.
module adder4bit (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout
);

   assign {Cout, Sum} = 5'(A) + 5'(B) + 5'(Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial W-bit adder: one 4-bit digit per cycle, LSB digit first.
// Optional macro SERIAL_SUB_EN enables A - B via op_sub (B inverted, carry-in 1).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*NIBBLES-1:0]  A,
   input  logic [4*NIBBLES-1:0]  B,
   input  logic                  Cin,
   input  logic                  op_sub,
   output logic                  busy,
   output logic [4*NIBBLES-1:0]  Sum,
   output logic                  Cout,
   output logic                  done
);

   localparam int unsigned W     = NIBBLE_W * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t              r_state;
   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
   logic [W-1:0]        r_acc;
   logic [IDX_W-1:0]    r_idx;
   logic                r_carry;

   logic [NIBBLE_W-1:0] w_da;
   logic [NIBBLE_W-1:0] w_db;
   logic [NIBBLE_W-1:0] w_dsum;
   logic                w_dcout;
   logic [W-1:0]        w_acc_next;

   // Select the current digit of each operand.
   assign w_da = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
   assign w_db = r_b[NIBBLE_W*r_idx +: NIBBLE_W];

   adder4bit u_adder4bit (
      .A    (w_da),
      .B    (w_db),
      .Cin  (r_carry),
      .Sum  (w_dsum),
      .Cout (w_dcout)
   );

   // Accumulator with the freshly computed digit merged in; feeds Sum on the last digit.
   always_comb begin
      w_acc_next = r_acc;
      w_acc_next[NIBBLE_W*r_idx +: NIBBLE_W] = w_dsum;
   end

`ifndef SERIAL_SUB_EN
   logic w_unused_op_sub;
   assign w_unused_op_sub = op_sub;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         busy    <= 1'b0;
         Sum     <= '0;
         Cout    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= A;
                  r_acc   <= '0;
                  r_idx   <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
`ifdef SERIAL_SUB_EN
                  if (op_sub) begin
                     r_b     <= ~B;
                     r_carry <= 1'b1;
                  end else begin
                     r_b     <= B;
                     r_carry <= Cin;
                  end
`else
                  r_b     <= B;
                  r_carry <= Cin;
`endif
               end
            end
            RUN: begin
               r_acc   <= w_acc_next;
               r_carry <= w_dcout;
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_state <= DONE;
                  Sum     <= w_acc_next;
                  Cout    <= w_dcout;
                  done    <= 1'b1;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random back-to-back additions.
module tb_serial_add_ctrl;

   localparam int unsigned NIB   = 4;
   localparam int unsigned W     = 4 * NIB;
   localparam int unsigned NRAND = 1000;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Cin;
   logic          op_sub;
   logic          busy;
   logic [W-1:0]  Sum;
   logic          Cout;
   logic          done;

   int n_checks;
   int n_errors;
   logic [W:0] exp_q[$];

   serial_add_ctrl #(.NIBBLES(NIB)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (A),
      .B      (B),
      .Cin    (Cin),
      .op_sub (op_sub),
      .busy   (busy),
      .Sum    (Sum),
      .Cout   (Cout),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on the operands as presented at acceptance.
   function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
      logic [W-1:0] nb;
      nb = ~b;
`ifdef SERIAL_SUB_EN
      if (sub) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
`else
      if (sub && (nb == b)) return '0;
`endif
      return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
   endfunction

   // One operation from idle; caller is at #1 after a rising edge. poke drives start/A mid-run.
   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic poke,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
      int lat;
      A = a; B = b; Cin = cin; op_sub = sub; start = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (poke) begin
         start = 1'b1;
         A = 16'hAAAA;
      end else begin
         start = 1'b0;
         A = W'($urandom);
      end
      B = W'($urandom); Cin = ~cin; op_sub = ~sub;
      lat = 0;
      for (int c = 1; c <= int'(NIB) + 6; c++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = c;
            break;
         end
      end
      chk({tag, "_lat"}, 32'(lat), 32'(NIB));
      chk({tag, "_sum"}, 32'(Sum), 32'(exp_sum));
      chk({tag, "_cout"}, 32'(Cout), 32'(exp_cout));
      @(posedge clk); #1;
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_hold"}, 32'(Sum), 32'(exp_sum));
      start = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0; op_sub = 1'b0;
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum",  32'(Sum),  32'd0);
      chk("rst_cout", 32'(Cout), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("basic",  16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0);
      do_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      do_op("ignore", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);

      // Abort in the second RUN cycle.
      A = 16'h1357; B = 16'h2468; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum",  32'(Sum),  32'd0);
      chk("abort_cout", 32'(Cout), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < int'(NIB) + 2; c++) begin
         @(posedge clk); #1;
         chk("abort_nodone", 32'(done), 32'd0);
      end
      do_op("post_rst", 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b0);

`ifdef SERIAL_SUB_EN
      do_op("sub_pos", 16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h000F, 1'b1);
      do_op("sub_neg", 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
`endif

      // Back-to-back random operations with start held high.
      fork
         begin
            for (int i = 0; i < int'(NRAND); i++) begin
               logic [W-1:0] a;
               logic [W-1:0] b;
               logic         ci;
               logic         sb;
               a  = W'($urandom);
               b  = W'($urandom);
               ci = 1'($urandom);
`ifdef SERIAL_SUB_EN
               sb = 1'($urandom);
`else
               sb = 1'b0;
`endif
               exp_q.push_back(ref_model(a, b, ci, sb));
               A = a; B = b; Cin = ci; op_sub = sb; start = 1'b1;
               repeat (NIB + 2) @(posedge clk);
               #1;
            end
            start = 1'b0;
         end
         begin
            int got;
            logic [W:0] e;
            got = 0;
            for (int c = 0; c < int'(NRAND * (NIB + 2)) + 20 && got < int'(NRAND); c++) begin
               @(posedge clk); #1;
               if (done) begin
                  if (exp_q.size() == 0) begin
                     chk("rnd_extra_done", 32'd1, 32'd0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("rnd_sum",  32'(Sum),  32'(e[W-1:0]));
                     chk("rnd_cout", 32'(Cout), 32'(e[W]));
                  end
                  got++;
               end
            end
            chk("rnd_done_cnt", 32'(got), 32'(NRAND));
         end
      join

      repeat (NIB + 3) @(posedge clk);
      #1;
      chk("final_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
